fu_dispatcher: RTL and testbench

FU_DISPATCHER -- requirements
Module: fu_dispatcher

---
 rtl/fu_dispatcher.sv | 150 +++++++++++++++
 tb/tb_fu_dispatcher.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fu_dispatcher.sv
// fu_dispatcher: accepts one command at a time, starts the addressed functional
// unit, hands it the shared vector memory port while it runs, and reports
// completion, illegal indices and watchdog timeouts.
//
// Ports:
//   clk_i, rst_i           clock, asynchronous active-high reset
//   cmd_valid_i/cmd_fu_i   command handshake and target FU index
//   cmd_ready_o            high only in IDLE
//   done_o, error_o        one-cycle completion / error pulses
//   busy_o                 command in flight (START or RUN)
//   cycle_count_o          duration of the last completed command
//   fu_ready_i/fu_start_o  per-FU start handshake
//   fu_vector_*_i          per-FU vector port requests
//   fu_vector_r_data_o     read data broadcast to every FU
//   vector_*               shared vector memory port
module fu_dispatcher #(
    parameter int unsigned NUM_FU         = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned DATA_W         = 32,
    // One extra bit so out-of-range indices are representable and reported.
    localparam int unsigned IDX_W         = $clog2(NUM_FU) + 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           cmd_valid_i,
    input  logic [IDX_W-1:0]               cmd_fu_i,
    output logic                           cmd_ready_o,
    output logic                           done_o,
    output logic                           error_o,
    output logic                           busy_o,
    output logic [31:0]                    cycle_count_o,
    input  logic [NUM_FU-1:0]              fu_ready_i,
    output logic [NUM_FU-1:0]              fu_start_o,
    input  logic [NUM_FU-1:0][ADDR_W-1:0]  fu_vector_addr_i,
    input  logic [NUM_FU-1:0]              fu_vector_w_en_i,
    input  logic [NUM_FU-1:0][DATA_W-1:0]  fu_vector_w_data_i,
    output logic [DATA_W-1:0]              fu_vector_r_data_o,
    output logic [ADDR_W-1:0]              vector_addr_o,
    output logic                           vector_w_en_o,
    output logic [DATA_W-1:0]              vector_w_data_o,
    input  logic [DATA_W-1:0]              vector_r_data_i
);

    localparam int unsigned SEL_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CYCLES);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;

    logic [1:0]       state, state_n;
    logic [SEL_W-1:0] sel, sel_n;
    logic [31:0]      count, count_n, count_inc;
    logic [31:0]      cycle_count_n;
    logic             done_n, error_n;
    logic             timeout;
    logic             illegal;

    assign count_inc = (count == 32'hFFFF_FFFF) ? count : count + 32'd1;
    assign timeout   = (count >= TIMEOUT_LIM);
    assign illegal   = (cmd_fu_i >= IDX_W'(NUM_FU));

    assign cmd_ready_o        = (state == IDLE);
    assign busy_o             = (state == START) || (state == RUN);
    assign fu_vector_r_data_o = vector_r_data_i;

    // State and datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= IDLE;
            sel           <= '0;
            count         <= '0;
            cycle_count_o <= '0;
            done_o        <= 1'b0;
            error_o       <= 1'b0;
        end else begin
            state         <= state_n;
            sel           <= sel_n;
            count         <= count_n;
            cycle_count_o <= cycle_count_n;
            done_o        <= done_n;
            error_o       <= error_n;
        end
    end

    // Next-state logic; the watchdog takes priority over start and completion.
    always_comb begin
        state_n       = state;
        sel_n         = sel;
        count_n       = count;
        cycle_count_n = cycle_count_o;
        done_n        = 1'b0;
        error_n       = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid_i) begin
                    if (illegal) begin
                        error_n = 1'b1;
                    end else begin
                        sel_n   = cmd_fu_i[SEL_W-1:0];
                        count_n = 32'd1;
                        state_n = START;
                    end
                end
            end
            START: begin
                count_n = count_inc;
                if (timeout) begin
                    error_n = 1'b1;
                    state_n = IDLE;
                end else if (fu_ready_i[sel]) begin
                    state_n = RUN;
                end
            end
            RUN: begin
                count_n = count_inc;
                if (timeout) begin
                    error_n = 1'b1;
                    state_n = IDLE;
                end else if (fu_ready_i[sel]) begin
                    done_n        = 1'b1;
                    cycle_count_n = count;
                    state_n       = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Start strobe and vector port mux; both are gated outside their states.
    // The start is withheld in a timeout cycle so no FU is launched and abandoned.
    always_comb begin
        fu_start_o      = '0;
        vector_addr_o   = '0;
        vector_w_en_o   = 1'b0;
        vector_w_data_o = '0;
        if ((state == START) && !timeout) begin
            fu_start_o[sel] = fu_ready_i[sel];
        end
        if (state == RUN) begin
            vector_addr_o   = fu_vector_addr_i[sel];
            vector_w_en_o   = fu_vector_w_en_i[sel];
            vector_w_data_o = fu_vector_w_data_i[sel];
        end
    end

endmodule

// File: tb/tb_fu_dispatcher.sv
// Self-checking bench for fu_dispatcher: FU behaviour models drive the per-FU
// inputs, a transaction-level reference model predicts every output each cycle,
// and directed scenarios pin the model with hand-computed literals.
module tb_fu_dispatcher;

    localparam int NF = 4;
    localparam int TO = 64;
    localparam int AW = 16;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cmd_valid;
    logic [2:0] cmd_fu;
    logic cmd_ready, done, error, busy;
    logic [31:0] cycle_count;
    logic [NF-1:0] fu_ready, fu_start, fu_wen;
    logic [NF-1:0][AW-1:0] fu_addr;
    logic [NF-1:0][DW-1:0] fu_wdata;
    logic [DW-1:0] fu_rdata, vwdata, vrdata;
    logic [AW-1:0] vaddr;
    logic vwen;

    always #5 clk = ~clk;

    fu_dispatcher #(
        .NUM_FU(NF), .TIMEOUT_CYCLES(TO), .ADDR_W(AW), .DATA_W(DW)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_fu_i(cmd_fu), .cmd_ready_o(cmd_ready),
        .done_o(done), .error_o(error), .busy_o(busy), .cycle_count_o(cycle_count),
        .fu_ready_i(fu_ready), .fu_start_o(fu_start),
        .fu_vector_addr_i(fu_addr), .fu_vector_w_en_i(fu_wen),
        .fu_vector_w_data_i(fu_wdata), .fu_vector_r_data_o(fu_rdata),
        .vector_addr_o(vaddr), .vector_w_en_o(vwen),
        .vector_w_data_o(vwdata), .vector_r_data_i(vrdata)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: one outstanding command, described as a transaction.
    bit m_busy, m_started, m_done, m_err;
    int m_sel;
    longint m_elapsed;
    logic [31:0] m_cc;

    // FU models: fu_left = busy cycles remaining after a start (-1 = forever).
    int fu_left[NF];
    int fu_hold[NF];
    int pending_dur[NF];
    bit rand_fu;
    bit force_wen_en;
    logic [NF-1:0] force_wen;

    int n_start, n_done, n_err, n_busy, n_wait, n_notready, n_vwen;
    logic [NF-1:0] last_start;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_started = 0; m_done = 0; m_err = 0;
        m_cc = '0; m_sel = 0; m_elapsed = 0;
    endtask

    task automatic drive_fu();
        for (int i = 0; i < NF; i++) begin
            if (rand_fu && fu_left[i] == 0 && fu_hold[i] == 0 && $urandom_range(15) == 0)
                fu_hold[i] = 1 + int'($urandom_range(3));
            fu_ready[i] = (fu_left[i] == 0) && (fu_hold[i] == 0);
            fu_addr[i]  = AW'($urandom);
            fu_wdata[i] = DW'($urandom);
            fu_wen[i]   = 1'($urandom_range(1));
        end
        if (force_wen_en) fu_wen = force_wen;
        vrdata = DW'($urandom);
    endtask

    // One clock cycle: compare at negedge, advance model, then FU models after posedge.
    task automatic tick();
        logic [NF-1:0] e_start, s_start;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        logic e_wen;
        @(negedge clk);
        e_start = '0; e_addr = '0; e_wen = 1'b0; e_wdata = '0;
        if (m_busy && !m_started && m_elapsed < TO) e_start[m_sel] = fu_ready[m_sel];
        if (m_busy && m_started) begin
            e_addr = fu_addr[m_sel]; e_wen = fu_wen[m_sel]; e_wdata = fu_wdata[m_sel];
        end
        check("cmd_ready", 64'(cmd_ready), 64'(!m_busy));
        check("busy", 64'(busy), 64'(m_busy));
        check("done", 64'(done), 64'(m_done));
        check("error", 64'(error), 64'(m_err));
        check("cycle_count", 64'(cycle_count), 64'(m_cc));
        check("fu_start", 64'(fu_start), 64'(e_start));
        check("vector_addr", 64'(vaddr), 64'(e_addr));
        check("vector_w_en", 64'(vwen), 64'(e_wen));
        check("vector_w_data", 64'(vwdata), 64'(e_wdata));
        check("fu_r_data", 64'(fu_rdata), 64'(vrdata));
        s_start = fu_start;
        if (fu_start != '0) begin n_start++; last_start = fu_start; end
        if (done) n_done++;
        if (error) n_err++;
        if (busy) n_busy++;
        if (!cmd_ready) n_notready++;
        if (vwen) n_vwen++;
        if (m_busy && !m_started && fu_start == '0) n_wait++;
        if (rst) begin
            model_reset();
        end else begin
            m_done = 0; m_err = 0;
            if (!m_busy) begin
                if (cmd_valid) begin
                    if (int'(cmd_fu) >= NF) m_err = 1;
                    else begin
                        m_busy = 1; m_started = 0; m_sel = int'(cmd_fu); m_elapsed = 1;
                    end
                end
            end else begin
                if (m_elapsed >= TO) begin
                    m_err = 1; m_busy = 0;
                end else if (fu_ready[m_sel]) begin
                    if (!m_started) m_started = 1;
                    else begin m_done = 1; m_cc = 32'(m_elapsed); m_busy = 0; end
                end
                if (m_busy && m_elapsed < 64'hFFFF_FFFF) m_elapsed++;
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NF; i++) begin
            if (s_start[i])
                fu_left[i] = rand_fu ? (($urandom_range(11) == 0) ? 70 : 1 + int'($urandom_range(11)))
                                     : pending_dur[i];
            else if (fu_left[i] > 0) fu_left[i]--;
            if (fu_hold[i] > 0) fu_hold[i]--;
        end
        drive_fu();
    endtask

    function automatic bit all_quiet();
        bit q = !m_busy && !m_done && !m_err;
        for (int i = 0; i < NF; i++) if (fu_left[i] != 0 || fu_hold[i] != 0) q = 0;
        return q;
    endfunction

    task automatic quiesce();
        int k = 0;
        cmd_valid = 1'b0; rand_fu = 0; force_wen_en = 0;
        while (!all_quiet() && k < 300) begin tick(); k++; end
        if (!all_quiet()) begin
            checks++; failures++;
            $display("FAIL quiesce: still active after %0d cycles", k);
        end
    endtask

    task automatic wait_done(input int budget, input string name);
        int k = 0;
        while (!(m_done || m_err) && k < budget) begin tick(); k++; end
        if (!(m_done || m_err)) begin
            checks++; failures++;
            $display("FAIL %s: no completion within %0d cycles", name, budget);
        end
        tick();
    endtask

    task automatic issue(input int fu);
        cmd_valid = 1'b1; cmd_fu = 3'(fu);
        tick();
        cmd_valid = 1'b0;
    endtask

    int s_done, s_start, s_err, s_busy, s_wait, s_nr, s_vwen;

    task automatic snap();
        s_done = n_done; s_start = n_start; s_err = n_err; s_busy = n_busy;
        s_wait = n_wait; s_nr = n_notready; s_vwen = n_vwen;
    endtask

    initial begin
        cmd_valid = 1'b0; cmd_fu = '0; rand_fu = 0; force_wen_en = 0; force_wen = '0;
        last_start = '0;
        for (int i = 0; i < NF; i++) begin fu_left[i] = 0; fu_hold[i] = 0; pending_dur[i] = 1; end
        model_reset();
        drive_fu();
        #2 rst = 1'b1;
        #1;
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_cycle_count", 64'(cycle_count), 64'd0);
        check("rst_fu_start", 64'(fu_start), 64'd0);
        check("rst_vector_addr", 64'(vaddr), 64'd0);
        repeat (2) tick();
        rst = 1'b0;

        // FU 1 busy 10 cycles after start.
        quiesce(); snap();
        pending_dur[1] = 10;
        issue(1);
        wait_done(40, "fu1_done");
        check("fu1_cycle_count", 64'(cycle_count), 64'd12);
        check("fu1_start_vec", 64'(last_start), 64'b0010);
        check("fu1_start_pulses", 64'(n_start - s_start), 64'd1);
        check("fu1_done_pulses", 64'(n_done - s_done), 64'd1);
        check("fu1_busy_cycles", 64'(n_busy - s_busy), 64'd12);

        // Illegal index.
        quiesce(); snap();
        issue(5);
        tick(); tick();
        check("bad_idx_err", 64'(n_err - s_err), 64'd1);
        check("bad_idx_start", 64'(n_start - s_start), 64'd0);
        check("bad_idx_not_ready", 64'(n_notready - s_nr), 64'd0);
        check("bad_idx_done", 64'(n_done - s_done), 64'd0);

        // FU 2 not ready for 5 cycles after the command.
        quiesce(); snap();
        pending_dur[2] = 3;
        issue(2);
        fu_hold[2] = 5; drive_fu();
        wait_done(40, "fu2_done");
        check("fu2_wait_cycles", 64'(n_wait - s_wait), 64'd5);
        check("fu2_start_pulses", 64'(n_start - s_start), 64'd1);
        check("fu2_start_vec", 64'(last_start), 64'b0100);
        check("fu2_cycle_count", 64'(cycle_count), 64'd10);

        // FU 3 never returns ready: watchdog.
        quiesce(); snap();
        pending_dur[3] = -1;
        force_wen_en = 1; force_wen = 4'b1000;
        issue(3);
        wait_done(100, "fu3_timeout");
        check("to_err", 64'(n_err - s_err), 64'd1);
        check("to_done", 64'(n_done - s_done), 64'd0);
        check("to_busy_cycles", 64'(n_busy - s_busy), 64'd64);
        check("to_cycle_count", 64'(cycle_count), 64'd10);
        snap();
        repeat (3) tick();
        check("to_wen_after", 64'(n_vwen - s_vwen), 64'd0);
        fu_left[3] = 0; force_wen_en = 0; drive_fu();

        // FU 0 running while FU 2 writes, then FU 0 writing itself.
        quiesce(); snap();
        pending_dur[0] = 8;
        force_wen_en = 1; force_wen = 4'b0100;
        issue(0);
        wait_done(40, "fu0_a");
        check("iso_wen_cycles", 64'(n_vwen - s_vwen), 64'd0);
        quiesce(); snap();
        force_wen_en = 1; force_wen = 4'b0001;
        issue(0);
        wait_done(40, "fu0_b");
        check("own_wen_cycles", 64'(n_vwen - s_vwen), 64'd9);

        // Reset mid-RUN, then back-to-back commands on the done cycle.
        quiesce(); snap();
        pending_dur[0] = 20;
        force_wen_en = 1; force_wen = 4'b0001;
        issue(0);
        repeat (5) tick();
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("arst_fu_start", 64'(fu_start), 64'd0);
        check("arst_wen", 64'(vwen), 64'd0);
        check("arst_addr", 64'(vaddr), 64'd0);
        check("arst_wdata", 64'(vwdata), 64'd0);
        check("arst_cycle_count", 64'(cycle_count), 64'd0);
        tick();
        rst = 1'b0;
        force_wen_en = 0;
        pending_dur[1] = 3; pending_dur[2] = 2;
        issue(1);
        begin
            int k = 0;
            while (!m_done && k < 30) begin tick(); k++; end
            if (!m_done) begin
                checks++; failures++;
                $display("FAIL b2b_first: no completion within 30 cycles");
            end
        end
        issue(2);
        wait_done(30, "b2b_second");
        check("b2b_done", 64'(n_done - s_done), 64'd2);
        check("b2b_err", 64'(n_err - s_err), 64'd0);
        check("b2b_cycle_count", 64'(cycle_count), 64'd4);

        // Randomized traffic with occasional asynchronous resets.
        rand_fu = 1; force_wen_en = 0;
        for (int n = 0; n < 4000; n++) begin
            cmd_valid = ($urandom_range(2) == 0);
            cmd_fu = 3'($urandom_range(5));
            if ($urandom_range(499) == 0) begin
                #2 rst = 1'b1;
                model_reset();
                tick();
                rst = 1'b0;
            end else begin
                tick();
            end
        end
        cmd_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
